// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable UART transmitter with a small TX FIFO.
//
// Bytes written through the wr_valid/wr_ready handshake are queued in a
// FIFO_DEPTH-entry FIFO and sent as frames:
//   start (0), 5..8 data bits LSB first, optional parity, 1 or 2 stop (1).
// Each bit lasts max(cfg_div,2) clocks. The cfg_* inputs are captured when
// a frame starts, so changing them mid-frame does not affect that frame.
//
// Ports:
//   clk, reset_n        clock (rising edge), asynchronous active-low reset
//   cfg_div             clocks per bit (0 and 1 behave as 2)
//   cfg_data_bits       00=5, 01=6, 10=7, 11=8 data bits
//   cfg_parity_en       append a parity bit after the data bits
//   cfg_parity_odd      1=odd parity, 0=even parity
//   cfg_stop2           1=two stop bits, 0=one stop bit
//   tx_enable           allows new frames to start
//   wr_valid, wr_data   write request and byte to queue
//   wr_ready            FIFO not full (combinational)
//   tx                  registered serial output, idle high
//   busy                a frame is in progress
//   frame_done          one-cycle pulse on the last clock of a frame
//   fifo_level          number of queued bytes
module uart_tx_cfg #(
    parameter int DIV_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [DIV_WIDTH-1:0]              cfg_div,
    input  logic [1:0]                        cfg_data_bits,
    input  logic                              cfg_parity_en,
    input  logic                              cfg_parity_odd,
    input  logic                              cfg_stop2,
    input  logic                              tx_enable,
    input  logic                              wr_valid,
    input  logic [7:0]                        wr_data,
    output logic                              wr_ready,
    output logic                              tx,
    output logic                              busy,
    output logic                              frame_done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [DIV_WIDTH-1:0] DIV_ONE    = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] DIV_TWO    = DIV_WIDTH'(2);
    localparam logic [LW-1:0]        LEVEL_FULL = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0]        LEVEL_ONE  = LW'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_d;
    logic          push;
    logic          pop;

    // A pop on the same edge does not make room for a write: ready only
    // reflects the registered level.
    assign wr_ready   = (level_q != LEVEL_FULL);
    assign push       = wr_valid && wr_ready;
    assign fifo_level = level_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_comb begin
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + LEVEL_ONE;
        end else if (pop && !push) begin
            level_d = level_q - LEVEL_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            level_q <= level_d;
        end
    end

    // ------------------------------------------------------------------
    // Frame sequencer
    // ------------------------------------------------------------------
    state_t                 state_q, state_d;
    logic [DIV_WIDTH-1:0]   baud_q, baud_d;
    logic [2:0]             bit_q, bit_d;
    logic [7:0]             data_q, data_d;
    logic [2:0]             last_q, last_d;
    logic                   par_en_q, par_en_d;
    logic                   par_odd_q, par_odd_d;
    logic                   stop2_q, stop2_d;
    logic [DIV_WIDTH-1:0]   div_q, div_d;
    logic                   tx_q, tx_d;

    logic                   start_ok;
    logic                   bit_end;
    logic                   launch;
    logic                   parity;
    logic [2:0]             next_bit;

    assign start_ok = tx_enable && (level_q != '0);
    assign bit_end  = (baud_q == div_q - DIV_ONE);
    assign next_bit = bit_q + 3'd1;
    assign busy     = (state_q != IDLE);
    assign tx       = tx_q;

    // Parity over the configured data bits only; higher bits are ignored.
    always_comb begin
        parity = par_odd_q;
        for (int unsigned i = 0; i < 8; i++) begin
            if (3'(i) <= last_q) begin
                parity = parity ^ data_q[3'(i)];
            end
        end
    end

    // tx_d is the line level for the state being entered, so tx changes on
    // the same edge as the state and stays registered.
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q + DIV_ONE;
        bit_d      = bit_q;
        tx_d       = tx_q;
        data_d     = data_q;
        last_d     = last_q;
        par_en_d   = par_en_q;
        par_odd_d  = par_odd_q;
        stop2_d    = stop2_q;
        div_d      = div_q;
        launch     = 1'b0;
        pop        = 1'b0;
        frame_done = 1'b0;

        case (state_q)
            IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                tx_d   = 1'b1;
                launch = start_ok;
            end
            START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = DATA;
                    tx_d    = data_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == last_q) begin
                        bit_d = '0;
                        if (par_en_q) begin
                            state_d = PARITY;
                            tx_d    = parity;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d = next_bit;
                        tx_d  = data_q[next_bit];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (stop2_q && (bit_q == 3'd0)) begin
                        bit_d = 3'd1;
                    end else begin
                        frame_done = 1'b1;
                        bit_d      = '0;
                        if (start_ok) begin
                            launch = 1'b1;
                        end else begin
                            state_d = IDLE;
                            tx_d    = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Frame start from IDLE or straight out of STOP: pop the head byte
        // and capture the configuration for the whole frame.
        if (launch) begin
            pop       = 1'b1;
            state_d   = START;
            tx_d      = 1'b0;
            baud_d    = '0;
            bit_d     = '0;
            data_d    = mem_q[rd_ptr_q];
            last_d    = {1'b1, cfg_data_bits};
            par_en_d  = cfg_parity_en;
            par_odd_d = cfg_parity_odd;
            stop2_d   = cfg_stop2;
            div_d     = (cfg_div < DIV_TWO) ? DIV_TWO : cfg_div;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            data_q    <= '0;
            last_q    <= 3'd7;
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            stop2_q   <= 1'b0;
            div_q     <= DIV_TWO;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            data_q    <= data_d;
            last_q    <= last_d;
            par_en_q  <= par_en_d;
            par_odd_q <= par_odd_d;
            stop2_q   <= stop2_d;
            div_q     <= div_d;
            tx_q      <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Testbench for uart_tx_cfg. Stimulus pushes the hand-derived line pattern
// of every frame it causes into a queue; an independent monitor detects
// start bits on tx and checks each frame against the head of the queue.
module tb_uart_tx_cfg;

    localparam int DW = 16;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [DW-1:0] cfg_div;
    logic [1:0]    cfg_data_bits;
    logic          cfg_parity_en;
    logic          cfg_parity_odd;
    logic          cfg_stop2;
    logic          tx_enable;
    logic          wr_valid;
    logic [7:0]    wr_data;
    logic          wr_ready;
    logic          tx;
    logic          busy;
    logic          frame_done;
    logic [2:0]    fifo_level;

    uart_tx_cfg #(.DIV_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cfg_div        (cfg_div),
        .cfg_data_bits  (cfg_data_bits),
        .cfg_parity_en  (cfg_parity_en),
        .cfg_parity_odd (cfg_parity_odd),
        .cfg_stop2      (cfg_stop2),
        .tx_enable      (tx_enable),
        .wr_valid       (wr_valid),
        .wr_data        (wr_data),
        .wr_ready       (wr_ready),
        .tx             (tx),
        .busy           (busy),
        .frame_done     (frame_done),
        .fifo_level     (fifo_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bits;   // line level per bit period, index 0 first
        int          len;    // number of bit periods
        int          div;    // clocks per bit period
        bit          gap0;   // must follow the previous frame with no idle
        bit          abort;  // frame is expected to be cut by reset
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   fails  = 0;
    bit   in_frame = 1'b0;
    int   idle_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push_exp(input string s, input int div, input bit gap0, input bit abort);
        exp_t e;
        e.bits = '0;
        for (int i = 0; i < s.len(); i++) begin
            e.bits[i] = (s[i] == "1");
        end
        e.len   = s.len();
        e.div   = div;
        e.gap0  = gap0;
        e.abort = abort;
        exp_q.push_back(e);
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    initial begin : monitor
        exp_t e;
        int   total;
        bit   ok_bit;
        bit   fd_ok;
        bit   aborted;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                idle_cnt++;
                continue;
            end
            if (tx === 1'b1) begin
                idle_cnt++;
                check("idle_frame_done", {31'b0, frame_done}, 32'd0);
            end else if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_frame: tx=%b with no frame expected at %0t", tx, $time);
                for (int k = 0; k < 500 && tx !== 1'b1 && reset_n; k++) @(negedge clk);
                idle_cnt = 0;
            end else begin
                e        = exp_q.pop_front();
                in_frame = 1'b1;
                total    = e.len * e.div;
                if (e.gap0) check("back_to_back_gap", idle_cnt, 0);
                check("busy_in_frame", {31'b0, busy}, 32'd1);
                aborted = 1'b0;
                fd_ok   = 1'b1;
                ok_bit  = 1'b1;
                for (int c = 0; c < total; c++) begin
                    if (c > 0) @(negedge clk);
                    if (!reset_n) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (tx !== e.bits[c / e.div]) ok_bit = 1'b0;
                    if (frame_done !== (c == total - 1)) fd_ok = 1'b0;
                    if ((c % e.div) == e.div - 1) begin
                        checks++;
                        if (!ok_bit) begin
                            fails++;
                            $display("FAIL frame_bit%0d: tx deviated during bit period, required %0b at %0t",
                                     c / e.div, e.bits[c / e.div], $time);
                        end
                        ok_bit = 1'b1;
                    end
                end
                check("frame_aborted", {31'b0, aborted}, {31'b0, e.abort});
                if (!aborted) check("frame_done_timing", {31'b0, fd_ok}, 32'd1);
                in_frame = 1'b0;
                idle_cnt = 0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic write_byte(input logic [7:0] d);
        @(negedge clk);
        wr_valid = 1'b1;
        wr_data  = d;
        @(posedge clk);
        #1 wr_valid = 1'b0;
    endtask

    task automatic set_cfg(input int div, input logic [1:0] db, input bit pe, input bit po, input bit s2);
        cfg_div        = DW'(div);
        cfg_data_bits  = db;
        cfg_parity_en  = pe;
        cfg_parity_odd = po;
        cfg_stop2      = s2;
    endtask

    task automatic wait_drain(input string name, input int max_cycles);
        int n = 0;
        while ((exp_q.size() != 0 || in_frame) && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'b0, (exp_q.size() == 0 && !in_frame)}, 32'd1);
        repeat (3) @(negedge clk);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        fails++;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [7:0] fill [5];
        fill[0] = 8'h01; fill[1] = 8'h02; fill[2] = 8'h13; fill[3] = 8'hE8; fill[4] = 8'h55;

        reset_n   = 1'b0;
        tx_enable = 1'b0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        set_cfg(4, 2'b11, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_tx", {31'b0, tx}, 32'd1);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_frame_done", {31'b0, frame_done}, 32'd0);
        check("reset_level", {29'b0, fifo_level}, 32'd0);
        check("reset_wr_ready", {31'b0, wr_ready}, 32'd1);
        @(negedge clk);
        reset_n = 1'b1;

        // 8N1, div 4, 0xA5; cfg changed mid-frame must be ignored
        tx_enable = 1'b1;
        push_exp("0101001011", 4, 1'b0, 1'b0);
        @(negedge clk);
        wr_valid = 1'b1;
        wr_data  = 8'hA5;
        @(posedge clk);
        #1 wr_valid = 1'b0;
        check("accept_edge_tx", {31'b0, tx}, 32'd1);
        check("accept_edge_level", {29'b0, fifo_level}, 32'd1);
        @(posedge clk);
        #1;
        check("start_edge_tx", {31'b0, tx}, 32'd0);
        check("start_edge_busy", {31'b0, busy}, 32'd1);
        check("start_edge_level", {29'b0, fifo_level}, 32'd0);
        set_cfg(8, 2'b00, 1'b1, 1'b1, 1'b1);
        wait_drain("drain_a5", 200);
        check("idle_busy", {31'b0, busy}, 32'd0);

        // 7E2, div 5, 0x03
        set_cfg(5, 2'b10, 1'b1, 1'b0, 1'b1);
        push_exp("01100000011", 5, 1'b0, 1'b0);
        write_byte(8'h03);
        wait_drain("drain_7e2", 200);

        // 8O1, div 3, 0x00 -> parity 1
        set_cfg(3, 2'b11, 1'b1, 1'b1, 1'b0);
        push_exp("00000000011", 3, 1'b0, 1'b0);
        write_byte(8'h00);
        wait_drain("drain_odd", 200);

        // div 0 -> 2 clocks per bit, 8N1, 0x5A
        set_cfg(0, 2'b11, 1'b0, 1'b0, 1'b0);
        push_exp("0010110101", 2, 1'b0, 1'b0);
        write_byte(8'h5A);
        wait_drain("drain_div0", 200);

        // Fill FIFO with tx disabled, fifth write dropped, then release
        tx_enable = 1'b0;
        set_cfg(2, 2'b00, 1'b0, 1'b0, 1'b0);
        push_exp("0100001", 2, 1'b0, 1'b0);
        push_exp("0010001", 2, 1'b1, 1'b0);
        push_exp("0110011", 2, 1'b1, 1'b0);
        push_exp("0000101", 2, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("fill_ready%0d", i), {31'b0, wr_ready}, (i < 4) ? 32'd1 : 32'd0);
            wr_valid = 1'b1;
            wr_data  = fill[i];
            @(posedge clk);
            #1 wr_valid = 1'b0;
            check($sformatf("fill_level%0d", i), {29'b0, fifo_level}, (i < 4) ? 32'(i + 1) : 32'd4);
        end
        check("full_wr_ready", {31'b0, wr_ready}, 32'd0);
        repeat (5) @(negedge clk);
        check("disabled_busy", {31'b0, busy}, 32'd0);
        tx_enable = 1'b1;
        wait_drain("drain_fifo", 300);
        check("fifo_empty_level", {29'b0, fifo_level}, 32'd0);

        // Reset in the middle of DATA with one byte still queued
        set_cfg(4, 2'b11, 1'b0, 1'b0, 1'b0);
        push_exp("0111111111", 4, 1'b0, 1'b1);
        write_byte(8'hFF);
        write_byte(8'h00);
        check("push_pop_level", {29'b0, fifo_level}, 32'd1);
        repeat (12) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("abort_tx", {31'b0, tx}, 32'd1);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_level", {29'b0, fifo_level}, 32'd0);
        check("abort_wr_ready", {31'b0, wr_ready}, 32'd1);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (60) @(negedge clk);
        check("post_reset_busy", {31'b0, busy}, 32'd0);
        check("post_reset_tx", {31'b0, tx}, 32'd1);
        check("post_reset_drained", {31'b0, (exp_q.size() == 0 && !in_frame)}, 32'd1);

        push_exp("0001111001", 4, 1'b0, 1'b0);
        write_byte(8'h3C);
        wait_drain("drain_after_reset", 200);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 SHALL have parameter DIV_WIDTH, default 16, width of the baud divisor input.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, TX FIFO entries; power of two, 2 or more.
REQ-003 SHALL have clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have cfg_div  input  DIV_WIDTH  clocks per bit; values 0 and 1 are treated as 2.
REQ-006 SHALL have cfg_data_bits  input  2  data bits per frame: 00=5, 01=6, 10=7, 11=8.
REQ-007 SHALL have cfg_parity_en  input  1  inserts a parity bit after the data bits.
REQ-008 SHALL have cfg_parity_odd  input  1  1=odd parity, 0=even parity.
REQ-009 SHALL have cfg_stop2  input  1  1=two stop bits, 0=one stop bit.
REQ-010 SHALL have tx_enable  input  1  permits new frames to start.
REQ-011 SHALL have wr_valid  input  1  write request.
REQ-012 SHALL have wr_data  input  8  byte to queue.
REQ-013 SHALL have wr_ready  output  1  FIFO not full.
REQ-014 SHALL have tx  output  1  serial line, registered, idle high.
REQ-015 SHALL have busy  output  1  a frame is in progress.
REQ-016 SHALL have frame_done  output  1  one-cycle pulse at the end of each frame.
REQ-017 SHALL have fifo_level  output  $clog2(FIFO_DEPTH+1)  current number of FIFO entries.

Function
REQ-018 SHALL accept a write on every rising edge where wr_valid and wr_ready are both 1; wr_valid while wr_ready=0 is ignored, not an error.
REQ-019 SHALL derive wr_ready combinationally as fifo_level != FIFO_DEPTH; a pop on the same edge does not raise wr_ready.
REQ-020 SHALL use FSM states IDLE, START, DATA, PARITY, STOP.
REQ-021 SHALL move IDLE->START when fifo_level > 0 and tx_enable=1, popping the head entry on that edge.
REQ-022 SHALL, on that edge, latch the popped byte and all cfg_* inputs; cfg changes mid-frame have no effect on the current frame.
REQ-023 SHALL drive tx=0 from the first rising edge after the accepting edge when a byte is written into an empty FIFO while in IDLE.
REQ-024 SHALL hold each bit for exactly max(cfg_div,2) clocks, timed by a bit counter cleared on frame start.
REQ-025 SHALL follow START with DATA, sending data bits LSB first; bits above the configured width are ignored.
REQ-026 SHALL send a PARITY bit when parity is enabled: XOR of the transmitted data bits for even parity, its inverse for odd parity.
REQ-027 SHALL send STOP as tx=1 for one or two bit periods.
REQ-028 SHALL pulse frame_done for one cycle on the last clock of STOP.
REQ-029 SHALL start the next frame immediately at the end of STOP when the FIFO is non-empty and tx_enable=1, with no idle cycles between frames.
REQ-030 SHALL let a frame in progress complete when tx_enable is deasserted; no new frame starts until tx_enable returns to 1.
REQ-031 SHALL assert busy in every state except IDLE.
REQ-032 SHALL handle a push and a pop on the same edge with net fifo_level unchanged and data order preserved.
REQ-033 SHALL hold tx=1 in IDLE.

Reset
REQ-034 SHALL, while reset_n=0, force tx=1, busy=0, frame_done=0, fifo_level=0 (wr_ready=1), FSM=IDLE, and clear all counters.
REQ-035 SHALL abort any frame in progress on reset, emptying the FIFO with no partial frame resumed afterwards.

Verification
REQ-036 SHALL cover: cfg_div=4, 8 data bits, no parity, 1 stop, write 0xA5 -> tx frame 0,1,0,1,0,0,1,0,1,1 with 4 clocks per bit, frame_done after 40 clocks.
REQ-037 SHALL cover: 7 data bits, even parity, 2 stop bits, write 0x03 -> data bits 1,1,0,0,0,0,0; parity 0; two stop bits; 11 bit periods total.
REQ-038 SHALL cover: odd parity, write 0x00 -> parity bit 1.
REQ-039 SHALL cover: fill FIFO_DEPTH+1 writes while tx_enable=0 -> wr_ready=0 at level 4, fifth write dropped; set tx_enable=1 -> 4 back-to-back frames with no idle gap, in write order.
REQ-040 SHALL cover: cfg_div=0 -> 2 clocks per bit.
REQ-041 SHALL cover: reset_n low mid-DATA -> tx=1, busy=0, fifo_level=0 immediately; no frame after release until a new write.
